// File: rtl/mcu420_chroma_aligner_pkg.sv
// Shared definitions for the 4:2:0 MCU chroma aligner.
//   - Channel tag encodings driven onto the supersample ch inputs.
//   - 8x8 / 4x4 block typedefs at the default sample width.
//   - MCU slot numbers for the chroma blocks.
//   - Quadrant origin helpers mapping a quadrant index to row/col offsets.
package mcu420_chroma_aligner_pkg;

    localparam int unsigned CH   = 2;
    localparam int unsigned CH_W = $clog2(CH + 1);

    localparam logic [CH_W-1:0] CH_Y  = CH_W'(0);
    localparam logic [CH_W-1:0] CH_CB = CH_W'(1);
    localparam logic [CH_W-1:0] CH_CR = CH_W'(2);

    localparam int unsigned SAMPLE_W = 8;

    typedef logic [7:0][7:0][SAMPLE_W-1:0] block8x8_t;
    typedef logic [3:0][3:0][SAMPLE_W-1:0] block4x4_t;

    localparam logic [2:0] SLOT_CB = 3'd4;
    localparam logic [2:0] SLOT_CR = 3'd5;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_EMIT    = 1'b1
    } state_e;

    // Quadrant k: bit 1 selects the bottom half, bit 0 the right half.
    function automatic logic [2:0] quad_row_off(input logic [1:0] k);
        return {k[1], 2'b00};
    endfunction

    function automatic logic [2:0] quad_col_off(input logic [1:0] k);
        return {k[0], 2'b00};
    endfunction

endpackage

// File: rtl/mcu420_chroma_aligner_chroma_quadrant_sel.sv
// Combinational 4x4 quadrant extractor for one 8x8 chroma block.
// Ports:
//   blk_i  : 8x8 chroma block, [row][col]
//   quad_i : quadrant index (0 TL, 1 TR, 2 BL, 3 BR)
//   quad_o : selected 4x4 quadrant, [row][col]
// The offsets are 0 or 4, so OR-ing them with a 2-bit row/col is a pure
// bit concatenation: the select is a mux, with no adders.
module chroma_quadrant_sel #(
    parameter int unsigned BW = 8
) (
    input  logic [7:0][7:0][BW-1:0] blk_i,
    input  logic [1:0]              quad_i,
    output logic [3:0][3:0][BW-1:0] quad_o
);
    import mcu420_chroma_aligner_pkg::*;

    always_comb begin
        quad_o = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                quad_o[2'(r)][2'(c)] = blk_i[quad_row_off(quad_i) | 3'(r)]
                                            [quad_col_off(quad_i) | 3'(c)];
            end
        end
    end

endmodule

// File: rtl/mcu420_chroma_aligner.sv
// 4:2:0 MCU chroma aligner. Collects Y0..Y3, Cb, Cr as six 8x8 blocks,
// then emits four tuples (Y block, matching Cb quadrant, matching Cr
// quadrant) in quadrant order TL, TR, BL, BR.
// Ports:
//   clock, reset         : clock, asynchronous active-high reset
//   valid_in, ready_out  : input block handshake (ready only while collecting)
//   blk_in               : 8x8 input block, [row][col]
//   valid_out, ready_in  : output tuple handshake
//   y_out                : luma block for the current quadrant
//   cb_out, cr_out       : 4x4 chroma quadrants
//   quad_idx             : current quadrant / Y block index
//   ch_cb, ch_cr         : constant channel tags for the supersamplers
module mcu420_chroma_aligner
    import mcu420_chroma_aligner_pkg::*;
#(
    parameter int unsigned BW = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic [7:0][7:0][BW-1:0] blk_in,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic [7:0][7:0][BW-1:0] y_out,
    output logic [3:0][3:0][BW-1:0] cb_out,
    output logic [3:0][3:0][BW-1:0] cr_out,
    output logic [1:0]              quad_idx,
    output logic [CH_W-1:0]         ch_cb,
    output logic [CH_W-1:0]         ch_cr
);

    state_e                  state_q;
    logic [2:0]              blk_cnt_q;
    logic [1:0]              quad_cnt_q;
    logic                    valid_out_q;
    logic [7:0][7:0][BW-1:0] mem_q [6];

    logic take;
    logic handshake;

    assign ready_out = (state_q == ST_COLLECT);
    assign take      = valid_in && ready_out;
    assign handshake = valid_out_q && ready_in;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_COLLECT;
            blk_cnt_q   <= '0;
            quad_cnt_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (take) begin
                        if (blk_cnt_q == SLOT_CR) begin
                            state_q     <= ST_EMIT;
                            blk_cnt_q   <= '0;
                            quad_cnt_q  <= '0;
                            valid_out_q <= 1'b1;
                        end else begin
                            blk_cnt_q <= blk_cnt_q + 3'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (handshake) begin
                        quad_cnt_q <= quad_cnt_q + 2'd1;
                        if (quad_cnt_q == 2'd3) begin
                            state_q     <= ST_COLLECT;
                            valid_out_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= ST_COLLECT;
            endcase
        end
    end

    // Block storage is deliberately not reset; a discarded partial MCU is
    // simply overwritten by the next collection starting at slot 0.
    always_ff @(posedge clock) begin
        if (take) begin
            mem_q[blk_cnt_q] <= blk_in;
        end
    end

    chroma_quadrant_sel #(.BW(BW)) u_cb_sel (
        .blk_i  (mem_q[SLOT_CB]),
        .quad_i (quad_cnt_q),
        .quad_o (cb_out)
    );

    chroma_quadrant_sel #(.BW(BW)) u_cr_sel (
        .blk_i  (mem_q[SLOT_CR]),
        .quad_i (quad_cnt_q),
        .quad_o (cr_out)
    );

    assign y_out     = mem_q[{1'b0, quad_cnt_q}];
    assign valid_out = valid_out_q;
    assign quad_idx  = quad_cnt_q;
    assign ch_cb     = CH_CB;
    assign ch_cr     = CH_CR;

endmodule

// File: tb/tb_mcu420_chroma_aligner.sv
module tb_mcu420_chroma_aligner;
    import mcu420_chroma_aligner_pkg::*;

    logic            clock;
    logic            reset;
    logic            valid_in;
    logic            ready_out;
    block8x8_t       blk_in;
    logic            valid_out;
    logic            ready_in;
    block8x8_t       y_out;
    block4x4_t       cb_out;
    block4x4_t       cr_out;
    logic [1:0]      quad_idx;
    logic [CH_W-1:0] ch_cb;
    logic [CH_W-1:0] ch_cr;

    int checks;
    int failures;

    mcu420_chroma_aligner #(.BW(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .blk_in    (blk_in),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .y_out     (y_out),
        .cb_out    (cb_out),
        .cr_out    (cr_out),
        .quad_idx  (quad_idx),
        .ch_cb     (ch_cb),
        .ch_cr     (ch_cr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Slot s, element [r][c] = s*64 + r*8 + c + off (mod 256)
    function automatic block8x8_t mk_block(input int s, input int off);
        block8x8_t b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r[2:0]][c[2:0]] = 8'((s * 64 + r * 8 + c + off) % 256);
        return b;
    endfunction

    // Quadrant k of slot s: rows 4*(k/2).., cols 4*(k%2)..
    function automatic block4x4_t mk_quad(input int s, input int k, input int off);
        block4x4_t q;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                q[r[1:0]][c[1:0]] = 8'((s * 64 + (4 * (k / 2) + r) * 8 + 4 * (k % 2) + c + off) % 256);
        return q;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_mcu(input int off);
        for (int s = 0; s < 6; s++) begin
            valid_in = 1'b1;
            blk_in   = mk_block(s, off);
            step();
        end
        valid_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_in = 1'b0; ready_in = 1'b0; blk_in = '0;
        step(); step();
        reset = 1'b0;
        checks++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0 || quad_idx !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got ready=%b valid=%b idx=%0d exp ready=1 valid=0 idx=0",
                     ready_out, valid_out, quad_idx);
        end
        checks++;
        if (ch_cb !== 2'b01 || ch_cr !== 2'b10) begin
            failures++;
            $display("FAIL ch_tags got cb=%b cr=%b exp cb=01 cr=10", ch_cb, ch_cr);
        end
    endtask

    task automatic test_basic();
        ready_in = 1'b1;
        for (int s = 0; s < 6; s++) begin
            checks++;
            if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
                failures++;
                $display("FAIL basic_collect s=%0d got valid=%b ready=%b exp valid=0 ready=1",
                         s, valid_out, ready_out);
            end
            valid_in = 1'b1;
            blk_in   = mk_block(s, 0);
            step();
        end
        valid_in = 1'b0;
        checks++;
        if (valid_out !== 1'b1 || ready_out !== 1'b0) begin
            failures++;
            $display("FAIL basic_latency got valid=%b ready=%b exp valid=1 ready=0", valid_out, ready_out);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (quad_idx !== 2'(k) || valid_out !== 1'b1) begin
                failures++;
                $display("FAIL basic_idx k=%0d got idx=%0d valid=%b exp idx=%0d valid=1", k, quad_idx, valid_out, k);
            end
            checks++;
            if (y_out !== mk_block(k, 0) || cb_out !== mk_quad(4, k, 0) || cr_out !== mk_quad(5, k, 0)) begin
                failures++;
                $display("FAIL basic_data k=%0d got y00=%0d cb00=%0d cr00=%0d exp y00=%0d cb00=%0d cr00=%0d",
                         k, y_out[0][0], cb_out[0][0], cr_out[0][0], k * 64, 8 * (k / 2) * 4 + 4 * (k % 2), 64 + 8 * (k / 2) * 4 + 4 * (k % 2));
            end
            if (k == 1) begin
                checks++;
                if (cb_out[0][0] !== 8'd4 || y_out[0][0] !== 8'd64) begin
                    failures++;
                    $display("FAIL basic_k1 got cb00=%0d y00=%0d exp cb00=4 y00=64", cb_out[0][0], y_out[0][0]);
                end
            end
            if (k == 3) begin
                checks++;
                if (cr_out[3][3] !== 8'd127) begin
                    failures++;
                    $display("FAIL basic_k3 got cr33=%0d exp cr33=127", cr_out[3][3]);
                end
            end
            step();
        end
        checks++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            failures++;
            $display("FAIL basic_done got valid=%b ready=%b exp valid=0 ready=1", valid_out, ready_out);
        end
    endtask

    task automatic test_backpressure();
        int hs;
        ready_in = 1'b1;
        send_mcu(1);
        step(); step();
        ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (quad_idx !== 2'd2 || valid_out !== 1'b1 || y_out !== mk_block(2, 1) ||
                cb_out !== mk_quad(4, 2, 1) || cr_out !== mk_quad(5, 2, 1)) begin
                failures++;
                $display("FAIL bp_hold i=%0d got idx=%0d valid=%b y00=%0d cb00=%0d exp idx=2 valid=1 y00=%0d cb00=%0d",
                         i, quad_idx, valid_out, y_out[0][0], cb_out[0][0], 129, 33);
            end
            step();
        end
        ready_in = 1'b1;
        hs = 2;
        for (int i = 0; i < 8 && valid_out === 1'b1; i++) begin
            checks++;
            if (quad_idx !== 2'(hs) || cr_out !== mk_quad(5, hs, 1)) begin
                failures++;
                $display("FAIL bp_resume got idx=%0d cr00=%0d exp idx=%0d", quad_idx, cr_out[0][0], hs);
            end
            hs++;
            step();
        end
        checks++;
        if (hs !== 4 || ready_out !== 1'b1) begin
            failures++;
            $display("FAIL bp_count got handshakes=%0d ready=%b exp handshakes=4 ready=1", hs, ready_out);
        end
    endtask

    task automatic test_gaps();
        ready_in = 1'b0;
        for (int i = 0; i < 11; i++) begin
            valid_in = (i % 2 == 0);
            blk_in   = (i % 2 == 0) ? mk_block(i / 2, 2) : mk_block(7, 55);
            step();
            checks++;
            if (valid_out !== (i == 10)) begin
                failures++;
                $display("FAIL gaps_valid i=%0d got valid=%b exp valid=%b", i, valid_out, (i == 10));
            end
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (quad_idx !== 2'(k) || y_out !== mk_block(k, 2) ||
                cb_out !== mk_quad(4, k, 2) || cr_out !== mk_quad(5, k, 2)) begin
                failures++;
                $display("FAIL gaps_data k=%0d got idx=%0d y00=%0d cb00=%0d exp idx=%0d y00=%0d",
                         k, quad_idx, y_out[0][0], cb_out[0][0], k, (k * 64 + 2) % 256);
            end
            step();
        end
    endtask

    task automatic test_emit_ignore();
        ready_in = 1'b0;
        send_mcu(0);
        valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            blk_in = mk_block(7 - i, 99);
            checks++;
            if (ready_out !== 1'b0 || valid_out !== 1'b1) begin
                failures++;
                $display("FAIL ignore_ready i=%0d got ready=%b valid=%b exp ready=0 valid=1", i, ready_out, valid_out);
            end
            step();
        end
        ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            blk_in = mk_block(k, 200);
            checks++;
            if (quad_idx !== 2'(k) || y_out !== mk_block(k, 0) ||
                cb_out !== mk_quad(4, k, 0) || cr_out !== mk_quad(5, k, 0)) begin
                failures++;
                $display("FAIL ignore_data k=%0d got idx=%0d y00=%0d cb00=%0d exp idx=%0d y00=%0d",
                         k, quad_idx, y_out[0][0], cb_out[0][0], k, k * 64);
            end
            step();
        end
        valid_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        ready_in = 1'b0;
        for (int s = 0; s < 3; s++) begin
            valid_in = 1'b1;
            blk_in   = mk_block(s, 3);
            step();
        end
        valid_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1 || quad_idx !== 2'd0) begin
            failures++;
            $display("FAIL rst_mid_collect got valid=%b ready=%b idx=%0d exp valid=0 ready=1 idx=0",
                     valid_out, ready_out, quad_idx);
        end
        step();
        reset = 1'b0;
        send_mcu(5);
        checks++;
        if (valid_out !== 1'b1 || quad_idx !== 2'd0 || y_out !== mk_block(0, 5)) begin
            failures++;
            $display("FAIL rst_clean_first got valid=%b idx=%0d y00=%0d exp valid=1 idx=0 y00=5",
                     valid_out, quad_idx, y_out[0][0]);
        end
        ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (quad_idx !== 2'(k) || y_out !== mk_block(k, 5) ||
                cb_out !== mk_quad(4, k, 5) || cr_out !== mk_quad(5, k, 5)) begin
                failures++;
                $display("FAIL rst_clean_data k=%0d got idx=%0d y00=%0d cr00=%0d exp idx=%0d y00=%0d",
                         k, quad_idx, y_out[0][0], cr_out[0][0], k, (k * 64 + 5) % 256);
            end
            step();
        end
        ready_in = 1'b0;
        send_mcu(6);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1 || quad_idx !== 2'd0) begin
            failures++;
            $display("FAIL rst_mid_emit got valid=%b ready=%b idx=%0d exp valid=0 ready=1 idx=0",
                     valid_out, ready_out, quad_idx);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        ready_in = 1'b1;
        send_mcu(10);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (quad_idx !== 2'(k) || y_out !== mk_block(k, 10) || cb_out !== mk_quad(4, k, 10)) begin
                failures++;
                $display("FAIL b2b_first k=%0d got idx=%0d y00=%0d exp idx=%0d y00=%0d",
                         k, quad_idx, y_out[0][0], k, (k * 64 + 10) % 256);
            end
            if (k == 3) begin
                valid_in = 1'b1;
                blk_in   = mk_block(0, 11);
                checks++;
                if (ready_out !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_no_overlap got ready=%b exp ready=0", ready_out);
                end
            end
            step();
        end
        checks++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
            failures++;
            $display("FAIL b2b_turnaround got ready=%b valid=%b exp ready=1 valid=0", ready_out, valid_out);
        end
        send_mcu(11);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (valid_out !== 1'b1 || quad_idx !== 2'(k) || y_out !== mk_block(k, 11) ||
                cb_out !== mk_quad(4, k, 11) || cr_out !== mk_quad(5, k, 11)) begin
                failures++;
                $display("FAIL b2b_second k=%0d got valid=%b idx=%0d y00=%0d cb00=%0d exp idx=%0d y00=%0d",
                         k, valid_out, quad_idx, y_out[0][0], cb_out[0][0], k, (k * 64 + 11) % 256);
            end
            step();
        end
        checks++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done got valid=%b ready=%b exp valid=0 ready=1", valid_out, ready_out);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_emit_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
